adc_scan_scheduler: RTL and testbench

- Owns the single shared ADC conversion port and shares it between two requesters: an autonomous round-robin channel scanner and a direct one-shot requester, which is the AHB-Lite bus bridge.
- Scan results are kept in a 16-entry result bank that software and the bridge can read without starting a conversion.
- Sits between the AHB bridge and the ADC core, with the same Read / Channel_Select / result / RDY_BSYn handshake on the ADC side.

---
 rtl/adc_scan_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//   Arbitrates the single ADC conversion port between a round-robin channel scanner
//   and a direct one-shot requester (the AHB bridge). Scan results land in a
//   16-entry result bank with per-entry fresh flags, readable without converting.
//
// Ports
//   HCLK, HRESETn    clock, asynchronous active-low reset
//   scan_en          enables autonomous scanning
//   chan_mask        bit n=1 includes channel n in the scan
//   scan_interval    idle cycles inserted after each completed pass
//   req_valid        direct request, held until req_done
//   req_channel      direct request channel
//   req_done         one-cycle pulse, direct result valid
//   req_result       direct result, held until the next req_done
//   req_err          qualifies req_done, 1 = conversion timed out
//   adc_read         conversion request to the ADC
//   adc_channel      channel select to the ADC
//   adc_result       ADC result, valid while adc_rdy=1
//   adc_rdy          ADC ready (1) / busy (0)
//   rd_channel       result-bank read index
//   rd_data          registered bank[rd_channel]
//   rd_fresh         registered fresh flag; entry written since its last read
//   pass_done        one-cycle pulse at the end of each scan pass
//   timeout_err      sticky timeout flag, cleared only by reset
//   busy             1 whenever the scheduler is not idle
module adc_scan_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned INTERVAL_W     = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  scan_en,
   input  logic [15:0]           chan_mask,
   input  logic [INTERVAL_W-1:0] scan_interval,
   input  logic                  req_valid,
   input  logic [3:0]            req_channel,
   output logic                  req_done,
   output logic [11:0]           req_result,
   output logic                  req_err,
   output logic                  adc_read,
   output logic [3:0]            adc_channel,
   input  logic [11:0]           adc_result,
   input  logic                  adc_rdy,
   input  logic [3:0]            rd_channel,
   output logic [11:0]           rd_data,
   output logic                  rd_fresh,
   output logic                  pass_done,
   output logic                  timeout_err,
   output logic                  busy
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StConvert,
      StRecover,
      StInterval
   } state_e;

   state_e                state_q;
   logic                  src_direct_q;   // current conversion belongs to the bridge
   logic                  end_pass_q;     // current scan conversion closes a pass
   logic                  last_direct_q;  // last grant went to the bridge
   logic [3:0]            ch_q;
   logic [3:0]            scan_ptr_q;
   logic [TmoW-1:0]       tmo_cnt_q;
   logic [INTERVAL_W-1:0] ivl_cnt_q;
   logic                  adc_read_q;
   logic                  req_done_q;
   logic [11:0]           req_result_q;
   logic                  req_err_q;
   logic                  pass_done_q;
   logic                  timeout_err_q;

   logic [11:0]           bank_q [16];
   logic [15:0]           fresh_q;
   logic [11:0]           rd_data_q;
   logic                  rd_fresh_q;

   logic                  scan_active;
   logic                  scan_hit;
   logic [3:0]            scan_next;
   logic [3:0]            mask_top;
   logic                  grant_direct;
   logic                  tmo_hit;
   logic                  bank_we;

   assign scan_active = scan_en && (chan_mask != 16'h0000);

   // Next masked channel strictly after the pointer, wrapping 15->0. The last
   // probe (i=16) lands back on the pointer itself so a one-bit mask still hits.
   always_comb begin
      scan_hit  = 1'b0;
      scan_next = 4'h0;
      for (int i = 1; i <= 16; i++) begin
         if (!scan_hit && chan_mask[scan_ptr_q + 4'(i)]) begin
            scan_hit  = 1'b1;
            scan_next = scan_ptr_q + 4'(i);
         end
      end
   end

   // A pass ends at the highest masked channel.
   always_comb begin
      mask_top = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (chan_mask[i]) begin
            mask_top = 4'(i);
         end
      end
   end

   // After a direct grant the scanner gets the next slot if it wants one.
   assign grant_direct = req_valid && !(last_direct_q && scan_active);
   assign tmo_hit      = !adc_rdy && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
   assign bank_we      = (state_q == StConvert) && !src_direct_q && adc_rdy;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q       <= StIdle;
         src_direct_q  <= 1'b0;
         end_pass_q    <= 1'b0;
         last_direct_q <= 1'b0;
         ch_q          <= 4'h0;
         scan_ptr_q    <= 4'hf;
         tmo_cnt_q     <= '0;
         ivl_cnt_q     <= '0;
         adc_read_q    <= 1'b0;
         req_done_q    <= 1'b0;
         req_result_q  <= 12'h000;
         req_err_q     <= 1'b0;
         pass_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         req_done_q  <= 1'b0;
         pass_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid || scan_active) begin
                  state_q <= StArb;
               end
            end
            StArb: begin
               tmo_cnt_q <= '0;
               if (grant_direct) begin
                  src_direct_q  <= 1'b1;
                  ch_q          <= req_channel;
                  end_pass_q    <= 1'b0;
                  last_direct_q <= 1'b1;
                  adc_read_q    <= 1'b1;
                  state_q       <= StConvert;
               end else if (scan_active && scan_hit) begin
                  src_direct_q  <= 1'b0;
                  ch_q          <= scan_next;
                  end_pass_q    <= (scan_next == mask_top);
                  last_direct_q <= 1'b0;
                  adc_read_q    <= 1'b1;
                  state_q       <= StConvert;
               end else begin
                  state_q <= StIdle;
               end
            end
            StConvert: begin
               if (adc_rdy || tmo_hit) begin
                  adc_read_q <= 1'b0;
                  state_q    <= StRecover;
                  if (!adc_rdy) begin
                     timeout_err_q <= 1'b1;
                  end
                  if (src_direct_q) begin
                     req_done_q <= 1'b1;
                     req_err_q  <= !adc_rdy;
                     if (adc_rdy) begin
                        req_result_q <= adc_result;
                     end
                  end else begin
                     scan_ptr_q  <= ch_q;
                     pass_done_q <= end_pass_q;
                  end
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
               end
            end
            StRecover: begin
               if (!src_direct_q && end_pass_q && (scan_interval != '0)) begin
                  ivl_cnt_q <= scan_interval - INTERVAL_W'(1);
                  state_q   <= StInterval;
               end else begin
                  state_q <= StArb;
               end
            end
            StInterval: begin
               // A direct request cuts the wait short; the remainder is dropped.
               if (req_valid || (ivl_cnt_q == '0)) begin
                  state_q <= StArb;
               end else begin
                  ivl_cnt_q <= ivl_cnt_q - INTERVAL_W'(1);
               end
            end
            default: begin
               state_q    <= StIdle;
               adc_read_q <= 1'b0;
            end
         endcase
      end
   end

   // Result bank and its registered read port. Reading clears the fresh flag,
   // but a write to the same entry in the same cycle keeps it set.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < 16; i++) begin
            bank_q[i] <= 12'h000;
         end
         fresh_q    <= 16'h0000;
         rd_data_q  <= 12'h000;
         rd_fresh_q <= 1'b0;
      end else begin
         rd_data_q            <= bank_q[rd_channel];
         rd_fresh_q           <= fresh_q[rd_channel];
         fresh_q[rd_channel]  <= 1'b0;
         if (bank_we) begin
            bank_q[ch_q]  <= adc_result;
            fresh_q[ch_q] <= 1'b1;
         end
      end
   end

   assign req_done    = req_done_q;
   assign req_result  = req_result_q;
   assign req_err     = req_err_q;
   assign adc_read    = adc_read_q;
   assign adc_channel = ch_q;
   assign rd_data     = rd_data_q;
   assign rd_fresh    = rd_fresh_q;
   assign pass_done   = pass_done_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
module tb_adc_scan_scheduler;

   logic        HCLK;
   logic        HRESETn;
   logic        scan_en;
   logic [15:0] chan_mask;
   logic [15:0] scan_interval;
   logic        req_valid;
   logic [3:0]  req_channel;
   logic        req_done;
   logic [11:0] req_result;
   logic        req_err;
   logic        adc_read;
   logic [3:0]  adc_channel;
   logic [11:0] adc_result;
   logic        adc_rdy;
   logic [3:0]  rd_channel;
   logic [11:0] rd_data;
   logic        rd_fresh;
   logic        pass_done;
   logic        timeout_err;
   logic        busy;

   adc_scan_scheduler #(
      .TIMEOUT_CYCLES (16),
      .INTERVAL_W     (16)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .scan_en       (scan_en),
      .chan_mask     (chan_mask),
      .scan_interval (scan_interval),
      .req_valid     (req_valid),
      .req_channel   (req_channel),
      .req_done      (req_done),
      .req_result    (req_result),
      .req_err       (req_err),
      .adc_read      (adc_read),
      .adc_channel   (adc_channel),
      .adc_result    (adc_result),
      .adc_rdy       (adc_rdy),
      .rd_channel    (rd_channel),
      .rd_data       (rd_data),
      .rd_fresh      (rd_fresh),
      .pass_done     (pass_done),
      .timeout_err   (timeout_err),
      .busy          (busy)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // ADC model: 5 busy cycles, then result 0x100+channel until adc_read drops.
   logic       adc_dead;
   logic [2:0] adc_cnt;
   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         adc_rdy    <= 1'b0;
         adc_cnt    <= 3'd0;
         adc_result <= 12'h000;
      end else if (adc_read && !adc_dead) begin
         if (adc_cnt == 3'd5) begin
            adc_rdy    <= 1'b1;
            adc_result <= 12'h100 + {8'h00, adc_channel};
         end else begin
            adc_cnt <= adc_cnt + 3'd1;
         end
      end else begin
         adc_rdy <= 1'b0;
         adc_cnt <= 3'd0;
      end
   end

   int total = 0;
   int bad   = 0;
   int pass_cnt = 0;
   logic [3:0]  exp_grant [$];
   logic [12:0] exp_req   [$];   // {err, result}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: checks every grant and every direct completion.
   logic read_prev = 1'b0;
   always @(negedge HCLK) begin
      if (adc_read && !read_prev) begin
         if (exp_grant.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant_unexpected: got ch %0d, required none", adc_channel);
         end else begin
            chk("grant_channel", {28'h0, adc_channel}, {28'h0, exp_grant.pop_front()});
         end
      end
      read_prev = adc_read;
      if (req_done) begin
         if (exp_req.size() == 0) begin
            total++;
            bad++;
            $display("FAIL req_done_unexpected: got 0x%0h err %0d, required none",
                     req_result, req_err);
         end else begin
            chk("req_result_err", {19'h0, req_err, req_result}, {19'h0, exp_req.pop_front()});
         end
      end
      if (pass_done) pass_cnt++;
   end

   function automatic bit ev_hit(input int ev);
      case (ev)
         0:       return req_done;
         1:       return pass_done;
         2:       return !busy;
         3:       return adc_read;
         default: return adc_read && (adc_channel == 4'd2);
      endcase
   endfunction

   task automatic wait_ev(input int ev, input string name);
      bit hit = 1'b0;
      for (int n = 0; n < 2000 && !hit; n++) begin
         @(negedge HCLK);
         hit = ev_hit(ev);
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL wait_%s: got no event in 2000 cycles, required event", name);
      end
   endtask

   task automatic rd_chk(input logic [3:0] ch, input logic [11:0] d, input logic f);
      rd_channel = ch;
      @(negedge HCLK);
      chk($sformatf("rd_data_ch%0d", ch), {20'h0, rd_data}, {20'h0, d});
      chk($sformatf("rd_fresh_ch%0d", ch), {31'h0, rd_fresh}, {31'h0, f});
      rd_channel = 4'd9;
   endtask

   initial begin
      int p0;
      int cnt;
      HRESETn       = 1'b0;
      scan_en       = 1'b0;
      chan_mask     = 16'h0000;
      scan_interval = 16'd0;
      req_valid     = 1'b0;
      req_channel   = 4'd0;
      rd_channel    = 4'd9;   // channel 9 is never written, so idle reads clear nothing
      adc_dead      = 1'b0;
      repeat (3) @(negedge HCLK);
      chk("rst_adc_read", {31'h0, adc_read}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_req_done", {31'h0, req_done}, 32'h0);
      chk("rst_pass_done", {31'h0, pass_done}, 32'h0);
      chk("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
      chk("rst_rd_data", {20'h0, rd_data}, 32'h0);
      HRESETn = 1'b1;
      @(negedge HCLK);

      // 1: round-robin scan over ch0,2,4 for two passes
      exp_grant = '{4'd0, 4'd2, 4'd4, 4'd0, 4'd2, 4'd4};
      p0 = pass_cnt;
      chan_mask = 16'h0015;
      scan_en   = 1'b1;
      wait_ev(1, "pass1");
      wait_ev(1, "pass2");
      scan_en = 1'b0;
      wait_ev(2, "idle1");
      chk("p1_pass_count", pass_cnt - p0, 32'd2);
      rd_chk(4'd0, 12'h100, 1'b1);
      rd_chk(4'd0, 12'h100, 1'b0);
      rd_chk(4'd2, 12'h102, 1'b1);
      rd_chk(4'd4, 12'h104, 1'b1);
      rd_chk(4'd1, 12'h000, 1'b0);

      // 2: direct request arrives during the ch2 conversion
      exp_grant = '{4'd0, 4'd2, 4'd7, 4'd4};
      exp_req   = '{{1'b0, 12'h107}};
      scan_en = 1'b1;
      wait_ev(4, "grant_ch2");
      req_valid   = 1'b1;
      req_channel = 4'd7;
      wait_ev(0, "req_done_ch7");
      req_valid = 1'b0;
      wait_ev(1, "pass_ch4");
      scan_en = 1'b0;
      wait_ev(2, "idle2");
      rd_chk(4'd2, 12'h102, 1'b1);

      // 3: ADC never ready, direct request on ch3 times out
      exp_grant = '{4'd3};
      exp_req   = '{{1'b1, 12'h107}};
      adc_dead    = 1'b1;
      req_valid   = 1'b1;
      req_channel = 4'd3;
      cnt = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge HCLK);
         if (adc_read) cnt++;
         if (req_done) break;
      end
      req_valid = 1'b0;
      chk("p3_read_high_cycles", cnt, 32'd16);
      chk("p3_timeout_err", {31'h0, timeout_err}, 32'h1);
      adc_dead = 1'b0;
      wait_ev(2, "idle3");
      exp_grant.push_back(4'd5);
      exp_req.push_back({1'b0, 12'h105});
      req_valid   = 1'b1;
      req_channel = 4'd5;
      wait_ev(0, "req_done_ch5");
      req_valid = 1'b0;
      wait_ev(2, "idle3b");
      chk("p3_timeout_sticky", {31'h0, timeout_err}, 32'h1);

      // 4: single channel 15 with a 10-cycle inter-pass gap
      exp_grant = '{4'd15, 4'd15, 4'd15};
      p0 = pass_cnt;
      chan_mask     = 16'h8000;
      scan_interval = 16'd10;
      scan_en       = 1'b1;
      wait_ev(1, "pass15a");
      cnt = 1;   // RECOVER cycle
      for (int n = 0; n < 100; n++) begin
         @(negedge HCLK);
         if (adc_read) break;
         cnt++;
      end
      chk("p4_read_low_gap", cnt, 32'd12);   // RECOVER + 10 INTERVAL + ARB
      wait_ev(1, "pass15b");
      wait_ev(1, "pass15c");
      scan_en = 1'b0;
      wait_ev(2, "idle4");
      chk("p4_pass_count", pass_cnt - p0, 32'd3);
      rd_chk(4'd15, 12'h10f, 1'b1);

      // 5: continuous direct stream against scan mask 0x0003
      exp_grant = '{4'd6, 4'd0, 4'd6, 4'd1, 4'd6, 4'd0, 4'd6, 4'd1};
      exp_req   = '{{1'b0, 12'h106}, {1'b0, 12'h106}, {1'b0, 12'h106}, {1'b0, 12'h106}};
      scan_interval = 16'd0;
      chan_mask     = 16'h0003;
      req_channel   = 4'd6;
      req_valid     = 1'b1;
      scan_en       = 1'b1;
      wait_ev(1, "pass_m3a");
      wait_ev(1, "pass_m3b");
      req_valid = 1'b0;
      scan_en   = 1'b0;
      wait_ev(2, "idle5");
      rd_chk(4'd1, 12'h101, 1'b1);

      // 6: reset during a conversion
      exp_grant = '{4'd2};
      chan_mask = 16'h0014;
      scan_en   = 1'b1;
      wait_ev(3, "read6");
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      chk("p6_async_read_drop", {31'h0, adc_read}, 32'h0);
      chk("p6_busy_in_reset", {31'h0, busy}, 32'h0);
      scan_en = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      chk("p6_timeout_cleared", {31'h0, timeout_err}, 32'h0);
      rd_chk(4'd0, 12'h000, 1'b0);
      rd_chk(4'd2, 12'h000, 1'b0);
      exp_grant.push_back(4'd2);
      scan_en = 1'b1;
      wait_ev(3, "read6b");
      scan_en = 1'b0;
      wait_ev(2, "idle6");
      rd_chk(4'd2, 12'h102, 1'b1);

      repeat (3) @(negedge HCLK);
      chk("grants_left", exp_grant.size(), 32'd0);
      chk("req_left", exp_req.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
